deal_sequencer: RTL and testbench
=================================

# deal_sequencer

Sequencer that deals the opening Blackjack hand, alternating player/dealer. It acts as the initiator side of the 2-second delay-timer handshake: it raises a timer request between cards and waits for the timer's done signal. It also requests each card from the card source and emits a one-cycle load strobe to the player or dealer hand register. It sits between the game FSM (start/done) and the delay counter and card source.

## Interface
- DEAL_COUNT, 4, number of cards dealt per start; even index goes to the player, odd index to the dealer; legal range 1..15
- CARD_W, 4, width of card value bus
- clk_50M  in  1  50 MHz system clock; all logic on rising edge
- i_Reset  in  1  synchronous, active-low reset; sampled on clk_50M
- i_Start  in  1  begin a deal; sampled only in IDLE
- o_DrawReq  out  1  one-cycle pulse requesting a card from the card source
- i_CardValid  in  1  card source presents i_Card; sampled only in WAIT_CARD
- i_Card  in  CARD_W  card value, captured when i_CardValid=1 in WAIT_CARD
- o_TimerReq  out  1  level; high for the whole WAIT_TIMER state; drives the delay timer's activate input
- i_TimerDone  in  1  delay elapsed (timer's 2-second flag)
- o_Card  out  CARD_W  last captured card; held until the next capture
- o_PlayerLoad  out  1  one-cycle strobe: o_Card goes to the player hand
- o_DealerLoad  out  1  one-cycle strobe: o_Card goes to the dealer hand
- o_Busy  out  1  high in every state except IDLE
- o_Done  out  1  one-cycle pulse when the deal completes

## Operation
- States: IDLE, DRAW, WAIT_CARD, LOAD, WAIT_TIMER, DONE.
- Index register r_Idx has width 4 and resets to 0.
- IDLE:
  - i_Start=1 → DRAW and r_Idx←0.
  - Otherwise stay in IDLE.
- DRAW:
  - o_DrawReq=1 for this cycle only.
  - Next state is WAIT_CARD unconditionally.
- WAIT_CARD:
  - On i_CardValid=1: o_Card←i_Card, then → LOAD.
  - Otherwise wait; there is no timeout.
- LOAD:
  - o_PlayerLoad=1 if r_Idx[0]=0, else o_DealerLoad=1. Exactly one of the two is high.
  - r_Idx←r_Idx+1.
  - If r_Idx+1 == DEAL_COUNT → DONE (no delay after the last card). Otherwise → WAIT_TIMER.
- WAIT_TIMER:
  - o_TimerReq=1.
  - i_TimerDone is ignored on the first cycle of the state; this guards against a stale done level.
  - From the second cycle on, i_TimerDone=1 → DRAW. o_TimerReq falls on the cycle DRAW is entered.
- DONE:
  - o_Done=1 for one cycle, then → IDLE.
- Ignored inputs:
  - i_Start outside IDLE (no queuing).
  - i_CardValid outside WAIT_CARD.
  - i_TimerDone outside WAIT_TIMER.
- o_Busy=1 in DRAW, WAIT_CARD, LOAD, WAIT_TIMER and DONE.

## Timing
- Reset (i_Reset=0 at a clock edge), effective at that edge:
  - State returns to IDLE and r_Idx=0.
  - o_Card=0.
  - All strobes, o_TimerReq, o_Busy and o_Done are 0.
  - This applies from any state, including mid-wait. An outstanding timer request is dropped immediately.
- Reset has priority over every other input in the same cycle.
- i_Start sampled at edge t → o_DrawReq high during cycle t+1.
- i_CardValid sampled at edge t → o_Card updated and load strobe high during cycle t+1.
- Load strobe in cycle t → o_TimerReq rises in cycle t+1, or o_Done in cycle t+1 for the last card.
- i_TimerDone accepted at edge t → o_DrawReq in cycle t+1.
- Minimum deal duration with an immediate card source and DEAL_COUNT=N: 3N+1 cycles from the Start edge to o_Done, plus (N−1) timer waits.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- DEAL_COUNT=1: a single player load, then DONE. The timer is never requested.

## Test plan
- Reset: with i_Reset=0 for 2 cycles mid-WAIT_TIMER (r_Idx=2) → next cycle IDLE, o_TimerReq=0, o_Card=0, o_Busy=0. A later i_Start restarts at r_Idx=0 with a player load first.
- Nominal deal: DEAL_COUNT=4, cards 0xA, 0x3, 0x7, 0xC each returned 1 cycle after o_DrawReq, i_TimerDone pulsed 5 cycles after o_TimerReq rises.
  - Loads occur as Player 0xA, Dealer 0x3, Player 0x7, Dealer 0xC.
  - Exactly 3 timer requests.
  - One o_Done pulse, then o_Busy=0.
- Stale/ignored inputs:
  - i_TimerDone held high when WAIT_TIMER is entered → no DRAW on the first WAIT_TIMER cycle; DRAW on the second.
  - i_CardValid pulsed during WAIT_TIMER → no strobe, and o_Card is unchanged.
- Start while busy: i_Start pulsed during WAIT_CARD → no restart and r_Idx is unaffected. Exactly DEAL_COUNT loads occur and one o_Done.
- Slow card source: i_CardValid delayed 50 cycles → o_DrawReq is a single pulse, the FSM holds in WAIT_CARD, and the load strobe occurs 1 cycle after valid.
- Edge parameter: DEAL_COUNT=1 with card 0x5 → one o_PlayerLoad with o_Card=0x5, o_TimerReq never high, o_Done 1 cycle after the load.

Source files
------------

// File: rtl/deal_sequencer.sv
// Opening-hand dealer: requests DEAL_COUNT cards one at a time, strobes each into
// the player (even index) or dealer (odd index) hand, with a timer wait between cards.
module deal_sequencer #(
    parameter int DEAL_COUNT = 4,
    parameter int CARD_W     = 4
) (
    input  logic              clk_50M,
    input  logic              i_Reset,
    input  logic              i_Start,
    output logic              o_DrawReq,
    input  logic              i_CardValid,
    input  logic [CARD_W-1:0] i_Card,
    output logic              o_TimerReq,
    input  logic              i_TimerDone,
    output logic [CARD_W-1:0] o_Card,
    output logic              o_PlayerLoad,
    output logic              o_DealerLoad,
    output logic              o_Busy,
    output logic              o_Done
);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] DRAW       = 3'd1;
    localparam logic [2:0] WAIT_CARD  = 3'd2;
    localparam logic [2:0] LOAD       = 3'd3;
    localparam logic [2:0] WAIT_TIMER = 3'd4;
    localparam logic [2:0] DONE       = 3'd5;

    // Index of the final card; the deal ends after the load at this index.
    localparam logic [3:0] LAST_IDX = 4'(DEAL_COUNT - 1);

    logic [2:0]        state_reg, state_next;
    logic [3:0]        idx_reg, idx_next;
    logic [CARD_W-1:0] card_reg, card_next;
    logic              timer_armed_reg, timer_armed_next;

    always_comb begin
        state_next       = state_reg;
        idx_next         = idx_reg;
        card_next        = card_reg;
        timer_armed_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (i_Start) begin
                    state_next = DRAW;
                    idx_next   = 4'd0;
                end
            end
            DRAW: begin
                state_next = WAIT_CARD;
            end
            WAIT_CARD: begin
                if (i_CardValid) begin
                    card_next  = i_Card;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                idx_next   = idx_reg + 4'd1;
                state_next = (idx_reg == LAST_IDX) ? DONE : WAIT_TIMER;
            end
            WAIT_TIMER: begin
                // Done is only honoured once the timer has seen our request for a
                // full cycle, so a done level left over from the previous wait is ignored.
                timer_armed_next = 1'b1;
                if (timer_armed_reg && i_TimerDone) begin
                    state_next = DRAW;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_50M) begin
        if (!i_Reset) begin
            state_reg       <= IDLE;
            idx_reg         <= 4'd0;
            card_reg        <= '0;
            timer_armed_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            idx_reg         <= idx_next;
            card_reg        <= card_next;
            timer_armed_reg <= timer_armed_next;
        end
    end

    // Every output is a decode of registered state, never of an input.
    assign o_DrawReq    = (state_reg == DRAW);
    assign o_TimerReq   = (state_reg == WAIT_TIMER);
    assign o_PlayerLoad = (state_reg == LOAD) && !idx_reg[0];
    assign o_DealerLoad = (state_reg == LOAD) &&  idx_reg[0];
    assign o_Busy       = (state_reg != IDLE);
    assign o_Done       = (state_reg == DONE);
    assign o_Card       = card_reg;

endmodule

// File: tb/tb_deal_sequencer.sv
// Bench for deal_sequencer: a 4-card instance driven by table and random deals,
// and a 1-card instance for the single-card edge case.
module tb_deal_sequencer;

    logic       clk_50M = 1'b0;
    logic       i_Reset;
    logic       i_Start, i_CardValid, i_TimerDone;
    logic [3:0] i_Card;
    logic       o_DrawReq, o_TimerReq, o_PlayerLoad, o_DealerLoad, o_Busy, o_Done;
    logic [3:0] o_Card;

    logic       s1_Start, s1_CardValid, s1_TimerDone;
    logic [3:0] s1_Card;
    logic       s1_DrawReq, s1_TimerReq, s1_PlayerLoad, s1_DealerLoad, s1_Busy, s1_Done;
    logic [3:0] s1_CardOut;

    always #10 clk_50M = ~clk_50M;

    deal_sequencer #(.DEAL_COUNT(4), .CARD_W(4)) dut (
        .clk_50M(clk_50M), .i_Reset(i_Reset), .i_Start(i_Start), .o_DrawReq(o_DrawReq),
        .i_CardValid(i_CardValid), .i_Card(i_Card), .o_TimerReq(o_TimerReq),
        .i_TimerDone(i_TimerDone), .o_Card(o_Card), .o_PlayerLoad(o_PlayerLoad),
        .o_DealerLoad(o_DealerLoad), .o_Busy(o_Busy), .o_Done(o_Done)
    );

    deal_sequencer #(.DEAL_COUNT(1), .CARD_W(4)) dut1 (
        .clk_50M(clk_50M), .i_Reset(i_Reset), .i_Start(s1_Start), .o_DrawReq(s1_DrawReq),
        .i_CardValid(s1_CardValid), .i_Card(s1_Card), .o_TimerReq(s1_TimerReq),
        .i_TimerDone(s1_TimerDone), .o_Card(s1_CardOut), .o_PlayerLoad(s1_PlayerLoad),
        .o_DealerLoad(s1_DealerLoad), .o_Busy(s1_Busy), .o_Done(s1_Done)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Event counters sampled just before each active edge.
    int   tmr_rises = 0, load_cnt = 0, done_cnt = 0, t1_rises = 0;
    logic tmr_prev = 1'b0, t1_prev = 1'b0;
    always @(posedge clk_50M) begin
        tmr_prev  <= o_TimerReq;
        t1_prev   <= s1_TimerReq;
        tmr_rises <= tmr_rises + ((o_TimerReq && !tmr_prev) ? 1 : 0);
        t1_rises  <= t1_rises + ((s1_TimerReq && !t1_prev) ? 1 : 0);
        load_cnt  <= load_cnt + ((o_PlayerLoad || o_DealerLoad) ? 1 : 0);
        done_cnt  <= done_cnt + (o_Done ? 1 : 0);
    end

    typedef struct {
        logic [15:0] cards;       // card i in bits [4i+3:4i]
        int          dly;         // extra WAIT_CARD cycles before valid
        int          tk;          // WAIT_TIMER cycle in which done is pulsed
        bit          stale;       // done already high when WAIT_TIMER is entered
        bit          noise;       // ignored inputs toggled during waits
        int          exp_cycles;  // Start edge to o_Done cycle
        int          exp_tmr;     // timer requests per deal
    } vec_t;

    vec_t vecs [6];

    logic [3:0] card_q [4];
    int         dly_q  [4];
    int         tk_q   [4];
    bit         stale_g, noise_g;

    task automatic step();
        @(negedge clk_50M);
        cyc++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int model_cycles(input int n);
        int e = 1;
        for (int i = 0; i < n; i++) begin
            e += 3 + dly_q[i];
            if (i < n - 1) e += (stale_g || tk_q[i] < 2) ? 2 : tk_q[i];
        end
        return e;
    endfunction

    // Plays card source and delay timer for one full deal; called at a negedge with the DUT idle.
    task automatic run_deal(input int n, input int exp_cycles, input int exp_tmr);
        int t0, l0, d0;
        t0 = tmr_rises; l0 = load_cnt; d0 = done_cnt;
        chk("idle_busy", o_Busy, 0);
        i_Start = 1'b1;
        cyc = 0;
        step();
        i_Start = 1'b0;
        for (int i = 0; i < n; i++) begin
            chk($sformatf("draw%0d", i), o_DrawReq, 1);
            step();
            for (int w = 0; w < dly_q[i]; w++) begin
                chk("wc_draw_single", o_DrawReq, 0);
                chk("wc_no_load", o_PlayerLoad | o_DealerLoad, 0);
                chk("wc_busy", o_Busy, 1);
                if (noise_g) begin
                    i_Start     = 1'($urandom_range(0, 1));
                    i_TimerDone = 1'($urandom_range(0, 1));
                end
                step();
            end
            i_Start = 1'b0; i_TimerDone = 1'b0;
            i_CardValid = 1'b1; i_Card = card_q[i];
            step();
            i_CardValid = 1'b0; i_Card = 4'($urandom);
            chk($sformatf("player_load%0d", i), o_PlayerLoad, (i % 2 == 0) ? 1 : 0);
            chk($sformatf("dealer_load%0d", i), o_DealerLoad, (i % 2 == 1) ? 1 : 0);
            chk($sformatf("card%0d", i), o_Card, card_q[i]);
            if (stale_g && i < n - 1) i_TimerDone = 1'b1;
            step();
            if (i == n - 1) begin
                chk("done_pulse", o_Done, 1);
                chk("done_no_timer", o_TimerReq, 0);
                chk("deal_cycles", cyc, exp_cycles);
                step();
                chk("done_single", o_Done, 0);
                chk("busy_after_done", o_Busy, 0);
            end else begin
                chk("timer_req", o_TimerReq, 1);
                chk("wt_no_draw", o_DrawReq, 0);
                if (stale_g) begin
                    step();
                    chk("stale_no_draw", o_DrawReq, 0);
                    chk("stale_timer_req", o_TimerReq, 1);
                    step();
                    i_TimerDone = 1'b0;
                end else begin
                    for (int w = 1; w < tk_q[i]; w++) begin
                        if (noise_g) begin
                            i_CardValid = 1'($urandom_range(0, 1));
                            i_Card      = 4'($urandom);
                            i_Start     = 1'($urandom_range(0, 1));
                        end
                        step();
                        chk("wt_no_load", o_PlayerLoad | o_DealerLoad, 0);
                        chk("wt_card_held", o_Card, card_q[i]);
                        chk("wt_timer_req", o_TimerReq, 1);
                        chk("wt_no_draw", o_DrawReq, 0);
                    end
                    i_CardValid = 1'b0; i_Start = 1'b0;
                    i_TimerDone = 1'b1;
                    step();
                    i_TimerDone = 1'b0;
                    if (tk_q[i] < 2) begin
                        chk("guard_no_draw", o_DrawReq, 0);
                        i_TimerDone = 1'b1;
                        step();
                        i_TimerDone = 1'b0;
                    end
                end
                chk("timer_req_falls", o_TimerReq, 0);
            end
        end
        chk("timer_req_count", tmr_rises - t0, exp_tmr);
        chk("load_count", load_cnt - l0, n);
        chk("done_count", done_cnt - d0, 1);
    endtask

    initial begin
        vecs[0] = '{16'hC73A, 0,  5, 1'b0, 1'b0, 28,  3};
        vecs[1] = '{16'h4321, 2,  2, 1'b0, 1'b0, 27,  3};
        vecs[2] = '{16'h0DEF, 0,  1, 1'b0, 1'b0, 19,  3};
        vecs[3] = '{16'h8B96, 1,  3, 1'b1, 1'b0, 23,  3};
        vecs[4] = '{16'h1F05, 50, 2, 1'b0, 1'b0, 219, 3};
        vecs[5] = '{16'h8642, 3,  4, 1'b0, 1'b1, 37,  3};

        i_Reset = 1'b0; i_Start = 1'b0; i_CardValid = 1'b0; i_TimerDone = 1'b0; i_Card = 4'h0;
        s1_Start = 1'b0; s1_CardValid = 1'b0; s1_TimerDone = 1'b0; s1_Card = 4'h0;
        stale_g = 1'b0; noise_g = 1'b0;
        step(); step();
        chk("rst_busy", o_Busy, 0);
        chk("rst_card", o_Card, 0);
        chk("rst_draw", o_DrawReq, 0);
        chk("rst_timer", o_TimerReq, 0);
        chk("rst_done", o_Done, 0);
        chk("rst_loads", o_PlayerLoad | o_DealerLoad, 0);
        chk("rst1_busy", s1_Busy, 0);
        i_Reset = 1'b1;
        step();

        foreach (vecs[v]) begin
            for (int i = 0; i < 4; i++) begin
                card_q[i] = vecs[v].cards[4*i +: 4];
                dly_q[i]  = vecs[v].dly;
                tk_q[i]   = vecs[v].tk;
            end
            stale_g = vecs[v].stale;
            noise_g = vecs[v].noise;
            run_deal(4, vecs[v].exp_cycles, vecs[v].exp_tmr);
            $display("vector %0d: cards=%h dly=%0d tk=%0d stale=%0b noise=%0b cycles=%0d",
                     v, vecs[v].cards, vecs[v].dly, vecs[v].tk, vecs[v].stale, vecs[v].noise, cyc);
        end

        // Reset in WAIT_TIMER after two cards, with Start asserted alongside it.
        i_Start = 1'b1;
        step();
        i_Start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            i_CardValid = 1'b1; i_Card = 4'(4'h9 - i);
            step();
            i_CardValid = 1'b0;
            step();
            if (i == 0) begin
                i_TimerDone = 1'b1;
                step(); step();
                i_TimerDone = 1'b0;
            end
        end
        chk("pre_rst_timer", o_TimerReq, 1);
        i_Reset = 1'b0; i_Start = 1'b1;
        for (int r = 0; r < 2; r++) begin
            step();
            chk("midrst_timer", o_TimerReq, 0);
            chk("midrst_busy", o_Busy, 0);
            chk("midrst_card", o_Card, 0);
            chk("midrst_draw", o_DrawReq, 0);
        end
        i_Reset = 1'b1; i_Start = 1'b0;
        step();
        chk("post_rst_idle", o_Busy, 0);
        card_q = '{4'h1, 4'h2, 4'h3, 4'h4};
        dly_q  = '{0, 0, 0, 0};
        tk_q   = '{2, 2, 2, 2};
        stale_g = 1'b0; noise_g = 1'b0;
        run_deal(4, 19, 3);
        $display("reset restart deal: cycles=%0d", cyc);

        // Randomised deals against the cycle/ordering model.
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 4; i++) begin
                card_q[i] = 4'($urandom_range(0, 15));
                dly_q[i]  = $urandom_range(0, 6);
                tk_q[i]   = $urandom_range(1, 6);
            end
            stale_g = ($urandom_range(0, 3) == 0);
            noise_g = 1'b1;
            run_deal(4, model_cycles(4), 3);
            $display("random deal %0d: cards=%h%h%h%h stale=%0b cycles=%0d",
                     r, card_q[3], card_q[2], card_q[1], card_q[0], stale_g, cyc);
        end

        // Single-card instance: one player load, no timer, done right after.
        begin
            int t0;
            t0 = t1_rises;
            s1_Start = 1'b1;
            step();
            s1_Start = 1'b0;
            chk("dc1_draw", s1_DrawReq, 1);
            step();
            s1_CardValid = 1'b1; s1_Card = 4'h5;
            step();
            s1_CardValid = 1'b0;
            chk("dc1_player", s1_PlayerLoad, 1);
            chk("dc1_dealer", s1_DealerLoad, 0);
            chk("dc1_card", s1_CardOut, 4'h5);
            step();
            chk("dc1_done", s1_Done, 1);
            chk("dc1_timer", s1_TimerReq, 0);
            step();
            chk("dc1_idle", s1_Busy, 0);
            chk("dc1_timer_never", t1_rises - t0, 0);
            $display("single-card deal: card=%h", s1_CardOut);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
